accumulation_controller: RTL and testbench
==========================================

# accumulation_controller

Sequences one inference window over an array of `NUM_NEURONS` spike accumulator elements. It clears the accumulators, counts a programmed number of timesteps while spikes are presented, and then scans the accumulated counts to find the winning output neuron (argmax). It sits between the host/top-level control and the output-layer accumulator array, and returns a class index and spike count through a valid/ready handshake.

## Interface
Parameters:
- `NUM_NEURONS`, default 10: number of accumulator elements scanned; must be ≥1.
- `DATA_WIDTH`, default 16: width of each accumulated count.
- `TS_WIDTH`, default 16: width of the timestep counter and of `num_timesteps`.
- `IDX_WIDTH`, default `$clog2(NUM_NEURONS)`, minimum 1: width of the class index.

Ports:
- `clk` input 1: clock; all logic is rising-edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: begins a window; sampled only in IDLE.
- `num_timesteps` input `TS_WIDTH`: window length; latched on an accepted `start`.
- `timestep_done` input 1: one-cycle pulse from the spike source at the end of each timestep.
- `acc_values` input `NUM_NEURONS*DATA_WIDTH`: packed accumulator outputs; neuron i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `reset_accumulation` output 1: drives the accumulators' synchronous clear.
- `accumulate_en` output 1: high while spikes may be presented.
- `busy` output 1: high in every state except IDLE.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `class_index` output `IDX_WIDTH`: winning neuron.
- `class_count` output `DATA_WIDTH`: accumulated count of the winning neuron.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, SCAN, OUTPUT.
- IDLE: when `start` is high, latch `num_timesteps` into `ts_target`, zero `ts_count`, and go to CLEAR.
- CLEAR: `reset_accumulation` is high for exactly one cycle, then the FSM goes to ACCUM. If `ts_target` is 0, it goes directly to SCAN instead. Every count is then 0, so the result is index 0, count 0.
- ACCUM:
  - `accumulate_en` is high.
  - Each `timestep_done` increments `ts_count`.
  - On the pulse where `ts_count + 1 == ts_target`, the FSM goes to SCAN.
  - `timestep_done` is ignored in every other state.
- SCAN:
  - On entry, `scan_idx` is 0, `max_val` is 0 and `max_idx` is 0.
  - Each cycle, compare `acc_values[scan_idx]` against `max_val`. Update only on strictly greater, so ties resolve to the lowest index.
  - After `scan_idx == NUM_NEURONS-1`, register the result and go to OUTPUT.
  - Comparison is unsigned.
- OUTPUT: `out_valid` is high and `class_index`/`class_count` are stable until `out_valid && out_ready`. Then the FSM returns to IDLE.
- Accumulators are not cleared after a window; counts stay readable until the next `start`.
- `start` is ignored in every state except IDLE (no queuing).
- `ts_count` never wraps: the exit compare happens before the increment could overflow.

## Timing
- Reset values: state IDLE; `reset_accumulation` 0, `accumulate_en` 0, `busy` 0, `out_valid` 0, `class_index` 0, `class_count` 0.
- Reset taken mid-window aborts immediately. The next window's CLEAR guarantees the accumulators are clean.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `start` is sampled at edge E0:
  - `reset_accumulation` and `busy` are high after E0.
  - `accumulate_en` is high after E0+1.
- The final `timestep_done` is sampled at edge E1. `accumulate_en` drops after E1, and SCAN runs for the next `NUM_NEURONS` cycles.
- `out_valid` rises after edge E1+`NUM_NEURONS`.
- If `out_ready` is already high, the handshake completes in one cycle, and the next `start` may be accepted one cycle later (IDLE).
- `acc_values` must be stable during SCAN. This holds because `accumulate_en` is low, so the spike source must not deliver spikes.

## Structure
- Shared package `snn_ctrl_pkg` holds:
  - the state enum `acc_ctrl_state_t` (IDLE, CLEAR, ACCUM, SCAN, OUTPUT);
  - the handshake-related widths;
  - a `clog2_min1` helper function for `IDX_WIDTH`.
- Sub-module `argmax_scanner`: serial compare/hold over the packed bus, with `scan_start` and `scan_done` handshake and `max_idx`/`max_val` outputs. The FSM instantiates one.
- The timestep counter stays inline in the controller.

## Test plan
- Basic window, `NUM_NEURONS`=10, `num_timesteps`=5, counts {3,7,2,9,1,0,4,9,5,6} → exactly 5 `timestep_done` pulses consumed; result is `class_index`=3, `class_count`=9 (tie resolved to lowest index); `out_valid` rises 10 cycles after the 5th pulse.
- `num_timesteps`=0 → one `reset_accumulation` pulse, no ACCUM cycles, result index 0, count 0.
- Backpressure: hold `out_ready` low for 20 cycles → `out_valid` and outputs stay stable; a `start` pulsed during that time is ignored; release → IDLE next cycle.
- Asserting `rstn` low mid-ACCUM after 2 of 4 timesteps → all outputs return to reset values immediately; a fresh `start` gives a full CLEAR pulse and a correct new result.
- All counts equal (e.g. 0xFFFF) → `class_index`=0, `class_count`=0xFFFF; `timestep_done` pulses in IDLE or SCAN are not counted.
- Back-to-back windows with `out_ready` tied high → second `start` accepted one cycle after the handshake; `reset_accumulation` pulses once per window.

Source files
------------

// File: rtl/snn_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : snn_ctrl_pkg
// Brief    : Shared types, default widths and helpers for the SNN control path
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package snn_ctrl_pkg;

    localparam int DEF_NUM_NEURONS = 10;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_TS_WIDTH    = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        SCAN   = 3'd3,
        OUTPUT = 3'd4
    } acc_ctrl_state_t;

    // A single-neuron array still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : argmax_scanner
// Brief    : Serial one-element-per-cycle argmax over a packed count bus
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module argmax_scanner
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH   = clog2_min1(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              scan_start_i,
    input  logic                              scan_en_i,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] acc_values_i,
    output logic                              scan_done_o,
    output logic [IDX_WIDTH-1:0]              max_idx_o,
    output logic [DATA_WIDTH-1:0]             max_val_o
);

    localparam int                   C_DEPTH    = 1 << IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    logic [DATA_WIDTH-1:0] w_elem [C_DEPTH];

    // Pad to a power of two so any index value selects a defined element.
    for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_unpack
        if (gi < NUM_NEURONS) begin : g_live
            assign w_elem[gi] = acc_values_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_elem[gi] = '0;
        end
    end

    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  max_idx_q;
    logic [DATA_WIDTH-1:0] max_val_q;
    logic [DATA_WIDTH-1:0] w_cur;
    logic                  w_take;
    logic [IDX_WIDTH-1:0]  w_best_idx;
    logic [DATA_WIDTH-1:0] w_best_val;

    // Strictly-greater update keeps the lowest index on ties.
    always_comb begin
        w_cur      = w_elem[idx_q];
        w_take     = (w_cur > max_val_q);
        w_best_idx = w_take ? idx_q : max_idx_q;
        w_best_val = w_take ? w_cur : max_val_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else if (scan_start_i) begin
            idx_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else if (scan_en_i) begin
            idx_q     <= idx_q + IDX_WIDTH'(1);
            max_idx_q <= w_best_idx;
            max_val_q <= w_best_val;
        end
    end

    // Results include the element compared this cycle, so the final
    // element's outcome is visible in the same cycle scan_done_o is high.
    assign scan_done_o = scan_en_i && (idx_q == C_LAST_IDX);
    assign max_idx_o   = w_best_idx;
    assign max_val_o   = w_best_val;

endmodule
`default_nettype wire

// File: rtl/accumulation_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : accumulation_controller
// Brief    : Inference-window sequencer: clear, count timesteps, argmax scan
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module accumulation_controller
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TS_WIDTH    = DEF_TS_WIDTH,
    parameter int IDX_WIDTH   = clog2_min1(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [TS_WIDTH-1:0]               num_timesteps,
    input  logic                              timestep_done,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] acc_values,
    output logic                              reset_accumulation,
    output logic                              accumulate_en,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_WIDTH-1:0]              class_index,
    output logic [DATA_WIDTH-1:0]             class_count
);

    acc_ctrl_state_t       state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_target_q, ts_target_d;
    logic [TS_WIDTH-1:0]   ts_count_q, ts_count_d;
    logic [IDX_WIDTH-1:0]  class_index_q, class_index_d;
    logic [DATA_WIDTH-1:0] class_count_q, class_count_d;

    logic                  w_scan_start;
    logic                  w_scan_done;
    logic [IDX_WIDTH-1:0]  w_max_idx;
    logic [DATA_WIDTH-1:0] w_max_val;
    logic [TS_WIDTH-1:0]   w_ts_inc;

    assign w_ts_inc = ts_count_q + TS_WIDTH'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            ts_target_q   <= '0;
            ts_count_q    <= '0;
            class_index_q <= '0;
            class_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ts_target_q   <= ts_target_d;
            ts_count_q    <= ts_count_d;
            class_index_q <= class_index_d;
            class_count_q <= class_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ts_target_d   = ts_target_q;
        ts_count_d    = ts_count_q;
        class_index_d = class_index_q;
        class_count_d = class_count_q;
        w_scan_start  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ts_target_d = num_timesteps;
                    ts_count_d  = '0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                // A zero-length window skips straight to scanning the
                // freshly cleared (all-zero) accumulators.
                if (ts_target_q == '0) begin
                    state_d      = SCAN;
                    w_scan_start = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (timestep_done) begin
                    ts_count_d = w_ts_inc;
                    if (w_ts_inc == ts_target_q) begin
                        state_d      = SCAN;
                        w_scan_start = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (w_scan_done) begin
                    class_index_d = w_max_idx;
                    class_count_d = w_max_val;
                    state_d       = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    argmax_scanner #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_scanner (
        .clk          (clk),
        .rstn         (rstn),
        .scan_start_i (w_scan_start),
        .scan_en_i    (state_q == SCAN),
        .acc_values_i (acc_values),
        .scan_done_o  (w_scan_done),
        .max_idx_o    (w_max_idx),
        .max_val_o    (w_max_val)
    );

    assign reset_accumulation = (state_q == CLEAR);
    assign accumulate_en      = (state_q == ACCUM);
    assign busy               = (state_q != IDLE);
    assign out_valid          = (state_q == OUTPUT);
    assign class_index        = class_index_q;
    assign class_count        = class_count_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulation_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_accumulation_controller
// Brief    : Directed self-checking bench with a per-cycle expectation timeline
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_accumulation_controller;

    localparam int N    = 10;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int IW   = 4;
    localparam int MAXC = 1200;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          timestep_done = 1'b0;
    logic          out_ready = 1'b1;
    logic [TW-1:0] num_timesteps = '0;
    logic [N*DW-1:0] acc_values;
    logic          reset_accumulation, accumulate_en, busy, out_valid;
    logic [IW-1:0] class_index;
    logic [DW-1:0] class_count;

    accumulation_controller #(
        .NUM_NEURONS (N),
        .DATA_WIDTH  (DW),
        .TS_WIDTH    (TW),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .num_timesteps      (num_timesteps),
        .timestep_done      (timestep_done),
        .acc_values         (acc_values),
        .reset_accumulation (reset_accumulation),
        .accumulate_en      (accumulate_en),
        .busy               (busy),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .class_index        (class_index),
        .class_count        (class_count)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  chk_on   = 1'b0;
    int  windows  = 0;
    int  ra_seen  = 0;

    // Expected output waveform, indexed by the number of rising edges seen.
    bit  exp_ra [MAXC];
    bit  exp_ae [MAXC];
    bit  exp_bz [MAXC];
    bit  exp_ov [MAXC];
    int  exp_ci [MAXC];
    int  exp_cc [MAXC];

    int  vals [N];
    int  wt   [N];
    bit  inj_on = 1'b0;
    logic [DW-1:0] acc [N] = '{default: 16'h5A5A};

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator array stand-in: synchronous clear, adds one spike batch.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset_accumulation)
                acc[i] <= '0;
            else if (accumulate_en && inj_on)
                acc[i] <= acc[i] + DW'(vals[i]);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign acc_values[g*DW +: DW] = acc[g];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
        end
    endtask

    function automatic void argmax(input int v [N], output int bi, output int bc);
        bi = 0;
        bc = 0;
        for (int i = 0; i < N; i++)
            if (v[i] > bc) begin
                bi = i;
                bc = v[i];
            end
    endfunction

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            chk("reset_accumulation", 32'(reset_accumulation), 32'(exp_ra[cyc]));
            chk("accumulate_en",      32'(accumulate_en),      32'(exp_ae[cyc]));
            chk("busy",               32'(busy),               32'(exp_bz[cyc]));
            chk("out_valid",          32'(out_valid),          32'(exp_ov[cyc]));
            chk("class_index",        32'(class_index),        32'(exp_ci[cyc]));
            chk("class_count",        32'(class_count),        32'(exp_cc[cyc]));
            if (reset_accumulation === 1'b1) ra_seen++;
        end
    end

    task automatic mark(input int k, input bit ra, input bit ae, input bit bz, input bit ov);
        if (k < MAXC) begin
            exp_ra[k] = ra;
            exp_ae[k] = ae;
            exp_bz[k] = bz;
            exp_ov[k] = ov;
        end
    endtask

    task automatic res_from(input int k, input int ci, input int cc);
        for (int j = k; j < MAXC; j++) begin
            exp_ci[j] = ci;
            exp_cc[j] = cc;
        end
    endtask

    task automatic adv(input bit ra, input bit ae, input bit bz, input bit ov);
        mark(cyc + 1, ra, ae, bz, ov);
        @(negedge clk);
    endtask

    task automatic add_batch();
        for (int i = 0; i < N; i++) wt[i] = (wt[i] + vals[i]) & 32'hFFFF;
    endtask

    task automatic begin_window(input int t);
        for (int i = 0; i < N; i++) wt[i] = 0;
        windows++;
        start         = 1'b1;
        num_timesteps = TW'(t);
        adv(1'b1, 1'b0, 1'b1, 1'b0);
        start         = 1'b0;
        num_timesteps = 16'hBEEF;
    endtask

    // Called on the cycle whose next edge enters scanning.
    task automatic finish_window(input int hold, input bit poke, input bit late,
                                 input int li, input int lc, input string nm);
        int s, v, y, ei, ec;
        s = cyc + 1;
        v = s + N;
        y = v + hold;
        argmax(wt, ei, ec);
        for (int k = s; k < v; k++)  mark(k, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = v; k <= y; k++) mark(k, 1'b0, 1'b0, 1'b1, 1'b1);
        mark(y + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        res_from(v, ei, ec);
        if (hold > 0) out_ready = 1'b0;
        @(negedge clk);
        timestep_done = 1'b0;
        inj_on        = 1'b0;
        if (late) begin
            timestep_done = 1'b1;
            @(negedge clk);
            timestep_done = 1'b0;
        end
        while (cyc < y) begin
            if (cyc == v - 1) chk({nm, "_valid_early"}, 32'(out_valid), 32'd0);
            start = poke && (cyc == v + 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_idx"}, 32'(class_index), li);
        chk({nm, "_cnt"}, 32'(class_count), lc);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_window(input int t, input int gap, input int hold, input bit poke,
                              input bit late, input int li, input int lc, input string nm);
        begin_window(t);
        for (int p = 1; p <= t; p++) begin
            repeat (gap) adv(1'b0, 1'b1, 1'b1, 1'b0);
            if (p == 1) begin
                inj_on = 1'b1;
                add_batch();
            end
            timestep_done = 1'b1;
            if (p < t) begin
                adv(1'b0, 1'b1, 1'b1, 1'b0);
                timestep_done = 1'b0;
                inj_on        = 1'b0;
            end
        end
        finish_window(hold, poke, late, li, lc, nm);
    endtask

    initial begin
        int bi, bc;

        vals = '{3, 7, 2, 9, 1, 0, 4, 9, 5, 6};
        argmax(vals, bi, bc);
        chk("model_tie_idx", bi, 3);
        chk("model_tie_cnt", bc, 9);
        vals = '{default: 16'hFFFF};
        argmax(vals, bi, bc);
        chk("model_eq_idx", bi, 0);
        chk("model_eq_cnt", bc, 32'hFFFF);

        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);

        // Basic window with a tie between neurons 3 and 7.
        vals = '{3, 7, 2, 9, 1, 0, 4, 9, 5, 6};
        run_window(5, 1, 0, 1'b0, 1'b0, 3, 9, "basic");

        // Zero-length window over accumulators left dirty by the last one.
        run_window(0, 1, 0, 1'b0, 1'b0, 0, 0, "zero_ts");

        // Backpressure with an ignored start while the result waits.
        vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        run_window(2, 2, 20, 1'b1, 1'b0, 9, 10, "backpressure");

        // Reset in the middle of accumulation, then a fresh window.
        vals = '{default: 8};
        begin_window(4);
        adv(1'b0, 1'b1, 1'b1, 1'b0);
        inj_on = 1'b1;
        add_batch();
        timestep_done = 1'b1;
        adv(1'b0, 1'b1, 1'b1, 1'b0);
        timestep_done = 1'b0;
        inj_on        = 1'b0;
        adv(1'b0, 1'b1, 1'b1, 1'b0);
        timestep_done = 1'b1;
        adv(1'b0, 1'b1, 1'b1, 1'b0);
        timestep_done = 1'b0;
        mark(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        mark(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        res_from(cyc + 1, 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_reset_accumulation", 32'(reset_accumulation), 32'd0);
        chk("rst_accumulate_en",      32'(accumulate_en),      32'd0);
        chk("rst_busy",               32'(busy),               32'd0);
        chk("rst_out_valid",          32'(out_valid),          32'd0);
        chk("rst_class_index",        32'(class_index),        32'd0);
        chk("rst_class_count",        32'(class_count),        32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        vals = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 1};
        run_window(4, 1, 0, 1'b0, 1'b0, 2, 5, "after_rst");

        // Equal counts; pulses in IDLE and during the scan must not count.
        vals = '{default: 16'hFFFF};
        timestep_done = 1'b1;
        inj_on        = 1'b1;
        adv(1'b0, 1'b0, 1'b0, 1'b0);
        adv(1'b0, 1'b0, 1'b0, 1'b0);
        timestep_done = 1'b0;
        inj_on        = 1'b0;
        run_window(1, 1, 0, 1'b0, 1'b1, 0, 32'hFFFF, "all_equal");

        // Back-to-back windows with the consumer always ready.
        vals = '{0, 4, 4, 1, 0, 0, 2, 0, 0, 3};
        run_window(2, 1, 0, 1'b0, 1'b0, 1, 4, "b2b_first");
        vals = '{1, 1, 1, 1, 1, 1, 1, 1, 6, 7};
        run_window(3, 2, 0, 1'b0, 1'b0, 9, 7, "b2b_second");

        repeat (4) @(negedge clk);
        chk("clear_pulses_per_window", ra_seen, windows);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
